// File: rtl/xcorr_pair_sched.sv
// xcorr_pair_sched: walks the cross-correlator through every unordered
// microphone pair (x<y) for each captured frame. It drives the channel selects,
// pulses start, and guards each pair with a watchdog. Each finished pair's peak
// lag and value are republished, tagged with the pair index.
module xcorr_pair_sched #(
   parameter int NUM_MICS       = 4,
   parameter int DATAWIDTH      = 24,
   parameter int LAG_W          = 12,
   parameter int TIMEOUT_CYCLES = 4096,
   localparam int NUM_PAIRS     = NUM_MICS * (NUM_MICS - 1) / 2,
   localparam int MIC_W         = $clog2(NUM_MICS),
   // a single pair still needs a 1-bit index
   localparam int PAIR_W        = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          frame_ready,
   output logic                          xc_start,
   output logic [MIC_W-1:0]              xc_sel_x,
   output logic [MIC_W-1:0]              xc_sel_y,
   input  logic                          xc_complete,
   input  logic signed [2*DATAWIDTH-1:0] xc_result,
   input  logic signed [LAG_W-1:0]       xc_lag,
   output logic                          lag_valid,
   output logic [PAIR_W-1:0]             lag_pair,
   output logic signed [LAG_W-1:0]       lag_out,
   output logic signed [2*DATAWIDTH-1:0] peak_out,
   output logic                          frame_done,
   output logic                          busy,
   output logic                          timeout_err,
   output logic                          frame_drop
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0]   WDOG_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [MIC_W-1:0]  LAST_MIC  = MIC_W'(NUM_MICS - 1);
   localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_PAIRS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_WAIT  = 3'd2,
      S_STORE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                          r_state;
   logic [MIC_W-1:0]                r_sel_x;
   logic [MIC_W-1:0]                r_sel_y;
   logic [PAIR_W-1:0]               r_pair;
   logic [WD_W-1:0]                 r_wdog;
   logic                            r_xc_start;
   logic                            r_lag_valid;
   logic                            r_frame_done;
   logic                            r_timeout_err;
   logic                            r_frame_drop;
   logic signed [LAG_W-1:0]         r_lag_out;
   logic signed [2*DATAWIDTH-1:0]   r_peak_out;

   logic w_row_end;
   logic w_last;
   logic w_expire;
   logic w_adv;

   // y has reached the last mic: the next pair starts a new x row
   assign w_row_end = (r_sel_y == LAST_MIC);
   assign w_last    = (r_pair == LAST_PAIR);
   // completion takes priority over a watchdog expiring in the same cycle
   assign w_expire  = (r_state == S_WAIT) && !xc_complete && (r_wdog == WDOG_LAST);
   assign w_adv     = (r_state == S_STORE) || w_expire;

   // Sequencing FSM with registered outputs; pair advance is shared by STORE and timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_sel_x       <= '0;
         r_sel_y       <= '0;
         r_pair        <= '0;
         r_wdog        <= '0;
         r_xc_start    <= 1'b0;
         r_lag_valid   <= 1'b0;
         r_frame_done  <= 1'b0;
         r_timeout_err <= 1'b0;
         r_frame_drop  <= 1'b0;
         r_lag_out     <= '0;
         r_peak_out    <= '0;
      end else begin
         r_xc_start   <= 1'b0;
         r_lag_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_drop <= frame_ready && (r_state != S_IDLE);

         case (r_state)
            S_IDLE: begin
               if (frame_ready) begin
                  r_sel_x       <= '0;
                  r_sel_y       <= MIC_W'(1);
                  r_pair        <= '0;
                  r_timeout_err <= 1'b0;
                  r_xc_start    <= 1'b1;
                  r_state       <= S_START;
               end
            end
            S_START: begin
               r_wdog  <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (xc_complete) begin
                  r_lag_out   <= xc_lag;
                  r_peak_out  <= xc_result;
                  r_lag_valid <= 1'b1;
                  r_state     <= S_STORE;
               end else if (r_wdog == WDOG_LAST) begin
                  r_timeout_err <= 1'b1;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            S_STORE: begin
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         if (w_adv) begin
            if (w_last) begin
               r_frame_done <= 1'b1;
               r_state      <= S_DONE;
            end else begin
               r_xc_start <= 1'b1;
               r_pair     <= r_pair + 1'b1;
               r_state    <= S_START;
               if (w_row_end) begin
                  r_sel_x <= r_sel_x + 1'b1;
                  r_sel_y <= r_sel_x + MIC_W'(2);
               end else begin
                  r_sel_y <= r_sel_y + 1'b1;
               end
            end
         end
      end
   end

   assign xc_start    = r_xc_start;
   assign xc_sel_x    = r_sel_x;
   assign xc_sel_y    = r_sel_y;
   assign lag_valid   = r_lag_valid;
   assign lag_pair    = r_pair;
   assign lag_out     = r_lag_out;
   assign peak_out    = r_peak_out;
   assign frame_done  = r_frame_done;
   assign busy        = (r_state != S_IDLE);
   assign timeout_err = r_timeout_err;
   assign frame_drop  = r_frame_drop;

endmodule
